mem_pipe_stage: RTL and testbench
=================================

// Module: mem_pipe_stage
// PURPOSE
//  Parametrised EX->MEM pipeline register with a valid/ready handshake, flush, and
//  registered load/store address-exception classification (AdEL=4, AdES=5).
//  Sits between the ALU stage and the data-memory/bridge stage.
//  After an exception leaves the stage, younger instructions are squashed until flush.
// PARAMETERS
//  SB_W        160        packed sideband width (PC4, PC8, MDO, RT, flags), passed through
//  DM_TOP      32'h2fff   last byte address of data memory (DM spans 0..DM_TOP)
//  DEV0_BASE   32'h7f00   device 0 first byte address
//  DEV1_BASE   32'h7f10   device 1 first byte address
//  DEV_RD_SPAN 12         readable bytes per device
//  DEV_WR_SPAN 8          writable bytes per device (count register read-only)
// PORTS
//  clk        in   1      clock
//  reset      in   1      synchronous, active-high reset
//  flush      in   1      exception-redirect flush from CP0
//  in_valid   in   1      upstream holds a valid instruction
//  in_ready   out  1      stage accepts this cycle
//  in_ir      in   32     instruction word
//  in_pc      in   32     instruction PC
//  in_addr    in   32     ALU result / effective address
//  in_sb      in   SB_W   sideband, passed through unchanged
//  in_exc     in   5      upstream exception code, 0 = none
//  out_valid  out  1      stage holds a valid instruction
//  out_ready  in   1      downstream accepts this cycle
//  out_ir     out  32     registered instruction (0 when squashed)
//  out_pc     out  32     registered PC
//  out_addr   out  32     registered address
//  out_sb     out  SB_W   registered sideband
//  out_exc    out  5      registered exception code
// BEHAVIOUR
//  - Reset: all out_* = 0, out_valid = 0, state = RUN. in_ready = 1 after reset.
//  - in_ready = !out_valid || out_ready (combinational; one register, no skid buffer).
//  - Accept = in_valid && in_ready; capture all fields on the same clock edge. Latency 1.
//  - out_valid && !out_ready: every output holds stable.
//  - Neither accept nor drain: out_valid holds. Drain without accept: out_valid <= 0.
//  - Classification, combinational on in_* and captured with the instruction:
//    loads  LW,LH,LHU,LB,LBU (op 23,21,25,20,24 hex); stores SW,SH,SB (op 2b,29,28 hex).
//    Misaligned: word needs addr[1:0]=0; half needs addr[0]=0; byte is never misaligned.
//    Legal range: DM [0,DM_TOP] for all widths. Device windows are [BASE,BASE+SPAN-1],
//    using DEV_RD_SPAN for loads and DEV_WR_SPAN for stores. Device accesses are word only:
//    a byte or half access to a device window is illegal.
//    Any violation: load -> 4, store -> 5. All compares unsigned 32-bit.
//  - Priority: in_exc != 0 is captured unchanged and overrides local classification.
//  - Non-memory opcodes: local code 0.
//  - FSM RUN/SQUASH: in RUN, a drain (out_valid&&out_ready) with out_exc!=0 moves to SQUASH.
//    In SQUASH, accepted instructions are captured as bubbles: ir=0, exc=0, pc kept, valid=1.
//  - flush: next edge out_valid<=0, out_ir<=0, out_exc<=0, state<=RUN.
//    flush beats a simultaneous accept, which is dropped. in_ready is unaffected by flush.
//  - reset beats flush.
//  - Address 0xffffffff: out of range, not wrapped.
// TESTING
//  1. LW addr 0x2ffc then SW addr 0x7f04, out_ready=1 -> out_exc 0,0; each output 1 cycle later.
//  2. LH 0x0001 -> 4; SH 0x0102 -> 0; SW 0x7f08 -> 5; LW 0x7f08 -> 0; LB 0x7f00 -> 4.
//  3. LW 0x3000 -> 4; SB 0x7f1c -> 5; LW 0xffffffff -> 4.
//  4. in_exc=10 on an illegal LW -> out_exc 10.
//  5. out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, outputs stable.
//     Release -> next instruction appears the following cycle.
//  6. Drain out_exc=5, feed 2 ADDs -> both out_ir=0, out_exc=0.
//     flush with in_valid=1 -> next cycle out_valid=0, state RUN, next ADD passes intact.

Source files
------------

// File: rtl/mem_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_pipe_stage
// Brief   : EX->MEM pipeline register with valid/ready handshake, flush and
//           registered load/store address-exception classification.
// Revision: 1.0 - initial release
// ============================================================================
module mem_pipe_stage #(
    parameter int unsigned SB_W        = 160,
    parameter logic [31:0] DM_TOP      = 32'h2fff,
    parameter logic [31:0] DEV0_BASE   = 32'h7f00,
    parameter logic [31:0] DEV1_BASE   = 32'h7f10,
    parameter int unsigned DEV_RD_SPAN = 12,
    parameter int unsigned DEV_WR_SPAN = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [31:0]     in_pc,
    input  logic [31:0]     in_addr,
    input  logic [SB_W-1:0] in_sb,
    input  logic [4:0]      in_exc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_ir,
    output logic [31:0]     out_pc,
    output logic [31:0]     out_addr,
    output logic [SB_W-1:0] out_sb,
    output logic [4:0]      out_exc
);

    localparam logic [5:0] c_OP_LB  = 6'h20;
    localparam logic [5:0] c_OP_LH  = 6'h21;
    localparam logic [5:0] c_OP_LW  = 6'h23;
    localparam logic [5:0] c_OP_LBU = 6'h24;
    localparam logic [5:0] c_OP_LHU = 6'h25;
    localparam logic [5:0] c_OP_SB  = 6'h28;
    localparam logic [5:0] c_OP_SH  = 6'h29;
    localparam logic [5:0] c_OP_SW  = 6'h2b;

    localparam logic [4:0] c_EXC_NONE = 5'd0;
    localparam logic [4:0] c_EXC_ADEL = 5'd4;
    localparam logic [4:0] c_EXC_ADES = 5'd5;

    localparam logic [31:0] c_DEV0_RD_LAST = DEV0_BASE + 32'(DEV_RD_SPAN) - 32'd1;
    localparam logic [31:0] c_DEV1_RD_LAST = DEV1_BASE + 32'(DEV_RD_SPAN) - 32'd1;
    localparam logic [31:0] c_DEV0_WR_LAST = DEV0_BASE + 32'(DEV_WR_SPAN) - 32'd1;
    localparam logic [31:0] c_DEV1_WR_LAST = DEV1_BASE + 32'(DEV_WR_SPAN) - 32'd1;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_valid;
    logic [31:0]     r_ir;
    logic [31:0]     r_pc;
    logic [31:0]     r_addr;
    logic [SB_W-1:0] r_sb;
    logic [4:0]      r_exc;

    logic [5:0]  w_op;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_word;
    logic        w_is_half;
    logic        w_misaligned;
    logic        w_in_dm;
    logic        w_in_dev_rd;
    logic        w_in_dev_wr;
    logic        w_in_dev;
    logic        w_addr_ok;
    logic [4:0]  w_local_exc;
    logic [4:0]  w_cap_exc;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_drain;
    logic        w_squash;

    assign w_op = in_ir[31:26];

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_is_word  = 1'b0;
        w_is_half  = 1'b0;
        case (w_op)
            c_OP_LW:           begin w_is_load  = 1'b1; w_is_word = 1'b1; end
            c_OP_LH, c_OP_LHU: begin w_is_load  = 1'b1; w_is_half = 1'b1; end
            c_OP_LB, c_OP_LBU: begin w_is_load  = 1'b1; end
            c_OP_SW:           begin w_is_store = 1'b1; w_is_word = 1'b1; end
            c_OP_SH:           begin w_is_store = 1'b1; w_is_half = 1'b1; end
            c_OP_SB:           begin w_is_store = 1'b1; end
            default:           ;
        endcase
    end

    assign w_misaligned = (w_is_word && (in_addr[1:0] != 2'b00)) ||
                          (w_is_half && in_addr[0]);
    assign w_in_dm      = (in_addr <= DM_TOP);
    assign w_in_dev_rd  = ((in_addr >= DEV0_BASE) && (in_addr <= c_DEV0_RD_LAST)) ||
                          ((in_addr >= DEV1_BASE) && (in_addr <= c_DEV1_RD_LAST));
    assign w_in_dev_wr  = ((in_addr >= DEV0_BASE) && (in_addr <= c_DEV0_WR_LAST)) ||
                          ((in_addr >= DEV1_BASE) && (in_addr <= c_DEV1_WR_LAST));
    // Device registers only decode full-word accesses.
    assign w_in_dev     = w_is_word && (w_is_load ? w_in_dev_rd : w_in_dev_wr);
    assign w_addr_ok    = !w_misaligned && (w_in_dm || w_in_dev);
    assign w_local_exc  = w_addr_ok  ? c_EXC_NONE :
                          w_is_load  ? c_EXC_ADEL :
                          w_is_store ? c_EXC_ADES : c_EXC_NONE;
    assign w_cap_exc    = (in_exc != c_EXC_NONE) ? in_exc : w_local_exc;

    assign w_in_ready = !r_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_drain    = r_valid && out_ready;
    // An instruction entering as an exception leaves is already younger than it.
    assign w_squash   = (r_state == ST_SQUASH) || (w_drain && (r_exc != c_EXC_NONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_valid <= 1'b0;
            r_ir    <= '0;
            r_pc    <= '0;
            r_addr  <= '0;
            r_sb    <= '0;
            r_exc   <= '0;
        end else if (flush) begin
            r_state <= ST_RUN;
            r_valid <= 1'b0;
            r_ir    <= '0;
            r_exc   <= '0;
        end else begin
            if ((r_state == ST_RUN) && w_drain && (r_exc != c_EXC_NONE)) begin
                r_state <= ST_SQUASH;
            end
            if (w_accept) begin
                r_valid <= 1'b1;
                r_ir    <= w_squash ? 32'd0 : in_ir;
                r_pc    <= in_pc;
                r_addr  <= in_addr;
                r_sb    <= in_sb;
                r_exc   <= w_squash ? c_EXC_NONE : w_cap_exc;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_ir    = r_ir;
    assign out_pc    = r_pc;
    assign out_addr  = r_addr;
    assign out_sb    = r_sb;
    assign out_exc   = r_exc;

endmodule
`default_nettype wire

// File: tb/tb_mem_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_pipe_stage
// Brief   : Self-checking bench for mem_pipe_stage (directed + random vs model).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_pipe_stage;

    localparam int SB_W = 160;
    localparam longint L_DM_TOP  = 64'h2fff;
    localparam longint L_DEV0    = 64'h7f00;
    localparam longint L_DEV1    = 64'h7f10;
    localparam longint L_RD_SPAN = 12;
    localparam longint L_WR_SPAN = 8;
    localparam logic [31:0] ADD_IR = 32'h01095020;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]     in_ir, in_pc, in_addr, out_ir, out_pc, out_addr;
    logic [SB_W-1:0] in_sb, out_sb;
    logic [4:0]      in_exc, out_exc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0]     ir;
        logic [31:0]     pc;
        logic [31:0]     addr;
        logic [SB_W-1:0] sb;
        logic [4:0]      exc;
    } txn_t;

    txn_t exp_q[$];
    bit   m_squash = 1'b0;

    always #5 clk = ~clk;

    mem_pipe_stage #(.SB_W(SB_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ir(in_ir), .in_pc(in_pc), .in_addr(in_addr), .in_sb(in_sb), .in_exc(in_exc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ir(out_ir), .out_pc(out_pc), .out_addr(out_addr), .out_sb(out_sb), .out_exc(out_exc)
    );

    // Exception code from the architectural rules: alignment, DM range, word-only device windows.
    function automatic logic [4:0] ref_exc(input logic [31:0] ir, input logic [31:0] addr,
                                           input logic [4:0] up);
        longint a, nbytes, span;
        bit     is_load, in_range;
        if (up != 5'd0) return up;
        case (ir[31:26])
            6'h20, 6'h24: begin nbytes = 1; is_load = 1'b1; end
            6'h21, 6'h25: begin nbytes = 2; is_load = 1'b1; end
            6'h23:        begin nbytes = 4; is_load = 1'b1; end
            6'h28:        begin nbytes = 1; is_load = 1'b0; end
            6'h29:        begin nbytes = 2; is_load = 1'b0; end
            6'h2b:        begin nbytes = 4; is_load = 1'b0; end
            default:      return 5'd0;
        endcase
        a        = {32'd0, addr};
        span     = is_load ? L_RD_SPAN : L_WR_SPAN;
        in_range = (a <= L_DM_TOP);
        if (nbytes == 4)
            in_range = in_range || (a >= L_DEV0 && a < L_DEV0 + span) ||
                                   (a >= L_DEV1 && a < L_DEV1 + span);
        if ((a % nbytes) == 0 && in_range) return 5'd0;
        return is_load ? 5'd4 : 5'd5;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [5:0] op);
        return {op, 5'd8, 5'd9, 16'h0010};
    endfunction

    task automatic set_in(input bit iv, input logic [31:0] ir, input logic [31:0] addr,
                          input logic [4:0] ex);
        in_valid = iv;
        in_ir    = ir;
        in_addr  = addr;
        in_exc   = ex;
        in_pc    = $urandom();
        in_sb    = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Advance one clock; the model consumes the inputs exactly as they stand at the edge.
    task automatic tick();
        txn_t t;
        bit   drain, acc, sq;
        drain = (exp_q.size() != 0) && out_ready;
        acc   = in_valid && ((exp_q.size() == 0) || out_ready);
        if (reset || flush) begin
            exp_q.delete();
            m_squash = 1'b0;
        end else begin
            sq = m_squash;
            if (drain) begin
                t = exp_q.pop_front();
                if (t.exc != 5'd0) begin
                    m_squash = 1'b1;
                    sq       = 1'b1;
                end
            end
            if (acc) begin
                t.ir   = sq ? 32'd0 : in_ir;
                t.pc   = in_pc;
                t.addr = in_addr;
                t.sb   = in_sb;
                t.exc  = sq ? 5'd0 : ref_exc(in_ir, in_addr, in_exc);
                exp_q.push_back(t);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clean();
        set_in(1'b0, 32'd0, 32'd0, 5'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, 5'd0);
        tick(); tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_ir, out_pc, out_addr, out_exc} !== 102'd0 || out_sb !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b ir=%h pc=%h addr=%h exc=%0d required all zero",
                     out_valid, out_ir, out_pc, out_addr, out_exc);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_latency();
        logic [31:0] irs [2];
        logic [31:0] ads [2];
        irs[0] = mk_ir(6'h23); ads[0] = 32'h2ffc;
        irs[1] = mk_ir(6'h2b); ads[1] = 32'h7f04;
        out_ready = 1'b1;
        set_in(1'b1, irs[0], ads[0], 5'd0);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_pre: out_valid=%b required 0", out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 1) set_in(1'b1, irs[1], ads[1], 5'd0);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_ir !== irs[i] || out_addr !== ads[i] || out_exc !== 5'd0) begin
                n_fail++;
                $display("FAIL latency[%0d]: valid=%b ir=%h addr=%h exc=%0d required 1 %h %h 0",
                         i, out_valid, out_ir, out_addr, out_exc, irs[i], ads[i]);
            end
        end
        set_in(1'b0, 32'd0, 32'd0, 5'd0);
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_classify();
        logic [5:0]  ops [15] = '{6'h21, 6'h29, 6'h2b, 6'h23, 6'h20, 6'h23, 6'h28, 6'h23,
                                  6'h23, 6'h23, 6'h2b, 6'h2b, 6'h25, 6'h24, 6'h00};
        logic [31:0] ads [15] = '{32'h0001, 32'h0102, 32'h7f08, 32'h7f08, 32'h7f00, 32'h3000,
                                  32'h7f1c, 32'hffffffff, 32'h3000, 32'h7f18, 32'h7f14,
                                  32'h7f18, 32'h2ffe, 32'h2fff, 32'h7f02};
        logic [4:0]  upx [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0};
        logic [4:0]  exp [15] = '{4, 0, 5, 0, 4, 4, 5, 4, 10, 0, 0, 5, 0, 0, 0};
        logic [31:0] ir;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            ir = (ops[i] == 6'h00) ? ADD_IR : mk_ir(ops[i]);
            set_in(1'b1, ir, ads[i], upx[i]);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_exc !== exp[i] || out_addr !== ads[i]) begin
                n_fail++;
                $display("FAIL classify[%0d]: valid=%b exc=%0d addr=%h required 1 %0d %h",
                         i, out_valid, out_exc, out_addr, exp[i], ads[i]);
            end
            clean();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pc0, ir1;
        logic [SB_W-1:0] sb0;
        out_ready = 1'b0;
        set_in(1'b1, mk_ir(6'h23), 32'h0100, 5'd0);
        pc0 = in_pc; sb0 = in_sb;
        tick();
        ir1 = mk_ir(6'h2b);
        set_in(1'b1, ir1, 32'h0200, 5'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_in_ready[%0d]: got %b required 0", c, in_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== pc0 || out_sb !== sb0 ||
                out_ir !== mk_ir(6'h23) || out_addr !== 32'h0100) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h ir=%h addr=%h required 1 %h %h 100",
                         c, out_valid, out_pc, out_ir, out_addr, pc0, mk_ir(6'h23));
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_in_ready: got %b required 1", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_ir !== ir1 || out_addr !== 32'h0200) begin
            n_fail++;
            $display("FAIL release_next: valid=%b ir=%h addr=%h required 1 %h 200",
                     out_valid, out_ir, out_addr, ir1);
        end
        clean();
    endtask

    task automatic test_squash_flush();
        logic [31:0] pc_a;
        out_ready = 1'b1;
        set_in(1'b1, mk_ir(6'h2b), 32'h7f08, 5'd0);
        tick();
        n_checks++;
        if (out_exc !== 5'd5) begin
            n_fail++;
            $display("FAIL squash_src: out_exc=%0d required 5", out_exc);
        end
        for (int k = 0; k < 2; k++) begin
            set_in(1'b1, ADD_IR, 32'h0, 5'd0);
            pc_a = in_pc;
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_ir !== 32'd0 || out_exc !== 5'd0 || out_pc !== pc_a) begin
                n_fail++;
                $display("FAIL bubble[%0d]: valid=%b ir=%h exc=%0d pc=%h required 1 0 0 %h",
                         k, out_valid, out_ir, out_exc, out_pc, pc_a);
            end
        end
        flush = 1'b1;
        set_in(1'b1, ADD_IR, 32'h0, 5'd0);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_in_ready: got %b required 1", in_ready);
        end
        tick();
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_ir !== 32'd0 || out_exc !== 5'd0) begin
            n_fail++;
            $display("FAIL flush_clear: valid=%b ir=%h exc=%0d required 0 0 0", out_valid, out_ir, out_exc);
        end
        set_in(1'b1, ADD_IR, 32'h1234, 5'd0);
        pc_a = in_pc;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_ir !== ADD_IR || out_exc !== 5'd0 || out_pc !== pc_a) begin
            n_fail++;
            $display("FAIL post_flush_run: valid=%b ir=%h exc=%0d pc=%h required 1 %h 0 %h",
                     out_valid, out_ir, out_exc, out_pc, ADD_IR, pc_a);
        end
        // Held output cleared by flush, then reset overriding a simultaneous flush.
        out_ready = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, 5'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_held: out_valid=%b required 0", out_valid);
        end
        set_in(1'b1, mk_ir(6'h23), 32'h0040, 5'd0);
        tick();
        reset = 1'b1; flush = 1'b1;
        set_in(1'b0, 32'd0, 32'd0, 5'd0);
        tick();
        reset = 1'b0; flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_addr !== 32'd0 || out_sb !== '0) begin
            n_fail++;
            $display("FAIL reset_beats_flush: valid=%b pc=%h addr=%h required 0 0 0",
                     out_valid, out_pc, out_addr);
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops [10] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b, 6'h00, 6'h0f};
        logic [31:0] bases [8] = '{32'h0, 32'h2ff8, 32'h3000, 32'h7efc, 32'h7f00, 32'h7f08,
                                   32'h7f10, 32'hfffffff8};
        logic [31:0] r, ad;
        logic [4:0]  ex;
        bit          exp_rdy;
        out_ready = 1'b1;
        for (int c = 0; c < 600; c++) begin
            r  = $urandom();
            ad = ($urandom_range(0, 9) == 0) ? $urandom() : bases[$urandom_range(0, 7)] + $urandom_range(0, 15);
            ex = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            set_in($urandom_range(0, 9) < 7, {ops[$urandom_range(0, 9)], r[25:0]}, ad, ex);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 6);
            #1;
            exp_rdy = (exp_q.size() == 0) || out_ready;
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_in_ready[%0d]: got %b required %b", c, in_ready, exp_rdy);
            end
            tick();
            n_checks++;
            if (out_valid !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL rand_valid[%0d]: got %b required %0d", c, out_valid, exp_q.size());
            end else if (exp_q.size() != 0) begin
                n_checks++;
                if (out_ir !== exp_q[0].ir || out_pc !== exp_q[0].pc || out_addr !== exp_q[0].addr ||
                    out_sb !== exp_q[0].sb || out_exc !== exp_q[0].exc) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: ir=%h pc=%h addr=%h exc=%0d required %h %h %h %0d",
                             c, out_ir, out_pc, out_addr, out_exc,
                             exp_q[0].ir, exp_q[0].pc, exp_q[0].addr, exp_q[0].exc);
                end
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_classify();
        test_backpressure();
        test_squash_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
